calc_entry_seq: RTL

// - Operand/operation entry sequencer for the lab calculator datapath, upstream of the operand and opcode registers.
// - Conditions two raw pushbuttons (enter, clear): synchronizer, debounce and rising-edge detect.
// - Steps the user through A -> B -> OP -> RESULT.
// - Emits one-cycle load enables into the en inputs of the A, B and opcode registers.
// - Emits a clear pulse into their reset inputs.

---
 rtl/calc_entry_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/calc_entry_seq.sv
// Calculator entry sequencer: conditions enter/clear pushbuttons and steps A -> B -> OP -> RESULT.
// Define CALC_ENTRY_TIMEOUT_EN to auto-clear after TIMEOUT_CYCLES idle cycles in RESULT.
module calc_entry_seq #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic       load_a,
    output logic       load_b,
    output logic       load_op,
    output logic       clr_regs,
    output logic [1:0] state_o,
    output logic       result_valid
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    // Index 0 is enter, index 1 is clear
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [DW-1:0]          db_cnt [2];
    logic [1:0]             stable_q;
    logic [1:0]             stable_d;
    logic [1:0]             press_q;

    assign raw = {btn_clear, btn_enter};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                sync_q[i] <= '0;
                db_cnt[i] <= '0;
            end
            stable_q <= '0;
            stable_d <= '0;
            press_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_q[i][SYNC_STAGES-1] == stable_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i]   <= '0;
                    stable_q[i] <= ~stable_q[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            stable_d <= stable_q;
            press_q  <= stable_q & ~stable_d;
        end
    end

    logic   enter_ev;
    logic   clear_ev;
    state_t state;
    state_t state_nx;
    logic   load_a_nx;
    logic   load_b_nx;
    logic   load_op_nx;
    logic   clr_nx;

    assign enter_ev = press_q[0];
    assign clear_ev = press_q[1];

`ifdef CALC_ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != S_RES || enter_ev || clear_ev) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nx   = state;
        load_a_nx  = 1'b0;
        load_b_nx  = 1'b0;
        load_op_nx = 1'b0;
        clr_nx     = 1'b0;
        if (clear_ev) begin
            clr_nx   = 1'b1;
            state_nx = S_A;
        end else if (enter_ev) begin
            case (state)
                S_A: begin
                    load_a_nx = 1'b1;
                    state_nx  = S_B;
                end
                S_B: begin
                    load_b_nx = 1'b1;
                    state_nx  = S_OP;
                end
                S_OP: begin
                    load_op_nx = 1'b1;
                    state_nx   = S_RES;
                end
                S_RES: begin
                    clr_nx   = 1'b1;
                    state_nx = S_A;
                end
            endcase
        end
`ifdef CALC_ENTRY_TIMEOUT_EN
        else if (state == S_RES && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            clr_nx   = 1'b1;
            state_nx = S_A;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_A;
            load_a       <= 1'b0;
            load_b       <= 1'b0;
            load_op      <= 1'b0;
            clr_regs     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            load_a       <= load_a_nx;
            load_b       <= load_b_nx;
            load_op      <= load_op_nx;
            clr_regs     <= clr_nx;
            result_valid <= (state_nx == S_RES);
        end
    end

    assign state_o = state;

endmodule
